// File: rtl/sv_rg_pkg.sv
// Shared types and constants for the sv_rg random block generator.
package sv_rg_pkg;

    localparam int unsigned LFSR_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LFSR_STEPS = 8;

    localparam logic [LFSR_W-1:0] LFSR_MASK    = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_2B3D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One right-shifting Galois step; a non-zero state never maps to zero.
    function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_MASK : {LFSR_W{1'b0}});
    endfunction

endpackage

// File: rtl/sv_rg_lfsr8.sv
// Combinational LFSR advance: eight Galois steps per call, one output byte's worth.
module sv_lfsr8
    import sv_rg_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_state
);

    always_comb begin
        o_state = i_state;
        for (int unsigned i = 0; i < LFSR_STEPS; i++) begin
            o_state = galois_step(o_state);
        end
    end

endmodule

// File: rtl/sv_rg.sv
// Random block generator: fills a BLOCK_SIZE-bit byte array from a 32-bit LFSR
// on request and holds it with a ready flag until the request drops.
module sv_rg
    import sv_rg_pkg::*;
#(
    parameter int unsigned       BLOCK_SIZE = 512,
    parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              u_i,
    output logic              r_o,
    output logic [BYTE_W-1:0] d_o [BLOCK_SIZE/8],
    input  logic              seed_v_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              busy_o
);

    localparam int unsigned     N_BYTES  = BLOCK_SIZE / 8;
    localparam int unsigned     CNT_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_busy;
    logic [BYTE_W-1:0]   r_data [N_BYTES];

    logic [LFSR_W-1:0]   w_lfsr_next;
    logic [LFSR_W-1:0]   w_seed_val;

    sv_lfsr8 u_lfsr8 (
        .i_state (r_lfsr),
        .o_state (w_lfsr_next)
    );

    // A zero seed would lock the LFSR, so it falls back to SEED.
    assign w_seed_val = (seed_i == '0) ? SEED : seed_i;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            for (int unsigned i = 0; i < N_BYTES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (seed_v_i) begin
                        r_lfsr <= w_seed_val;
                    end
                    if (u_i) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // Dropping the request aborts; bytes written so far and the LFSR are kept.
                ST_FILL: begin
                    if (!u_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_lfsr        <= w_lfsr_next;
                        r_data[r_cnt] <= w_lfsr_next[BYTE_W-1:0];
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_DONE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    if (!u_i) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign r_o    = r_ready;
    assign busy_o = r_busy;
    assign d_o    = r_data;

endmodule

// File: tb/tb_sv_rg.sv
// Directed bench for sv_rg: block contents against a software LFSR model.
module tb_sv_rg;

    localparam int unsigned NB    = 64;
    localparam logic [31:0] SEED  = 32'hACE1_2B3D;
    localparam logic [31:0] POLY  = 32'h8020_0003;

    logic        clk      = 1'b0;
    logic        areset   = 1'b1;
    logic        u_i      = 1'b0;
    logic        seed_v_i = 1'b0;
    logic [31:0] seed_i   = 32'h0;
    logic        r_o;
    logic        busy_o;
    logic [7:0]  d_o [NB];

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_lfsr;

    always #5 clk = ~clk;

    sv_rg #(.BLOCK_SIZE(512), .SEED(SEED)) dut (
        .clk      (clk),
        .areset   (areset),
        .u_i      (u_i),
        .r_o      (r_o),
        .d_o      (d_o),
        .seed_v_i (seed_v_i),
        .seed_i   (seed_i),
        .busy_o   (busy_o)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] obs_block();
        logic [511:0] v;
        for (int i = 0; i < NB; i++) v[i*8 +: 8] = d_o[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Software model: advance 8 Galois steps per byte, take the low byte.
    task automatic model_bytes(input int n, input logic [511:0] base, output logic [511:0] blk);
        logic lsb;
        blk = base;
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 8; s++) begin
                lsb    = m_lfsr[0];
                m_lfsr = m_lfsr >> 1;
                if (lsb) m_lfsr = m_lfsr ^ POLY;
            end
            blk[i*8 +: 8] = m_lfsr[7:0];
        end
    endtask

    // seed_at: -1 none, 0 together with the request, k>0 after k cycles of the request.
    task automatic request_block(input int seed_at, input logic [31:0] sd,
                                 output int n_busy, output int n_cyc);
        n_busy = 0;
        n_cyc  = 0;
        @(negedge clk);
        u_i      = 1'b1;
        seed_i   = sd;
        seed_v_i = (seed_at == 0);
        while (n_cyc < 200) begin
            tick();
            n_cyc++;
            if (busy_o) n_busy++;
            seed_v_i = (n_cyc == seed_at);
            if (r_o) break;
        end
        seed_v_i = 1'b0;
    endtask

    task automatic release_req();
        @(negedge clk);
        u_i = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] exp;
        logic [511:0] prev;
        logic [511:0] blk_a0;
        int           nb;
        int           nc;
        logic         saw_ready;

        repeat (2) tick();
        @(negedge clk);
        areset = 1'b0;
        check("rst_r_o", r_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_data", obs_block(), '0);

        // First block after reset, default seed.
        m_lfsr = SEED;
        model_bytes(NB, '0, blk_a0);
        request_block(-1, 32'h0, nb, nc);
        check("blk0_busy_cycles", nb, 64);
        check("blk0_ready_cycle", nc, 65);
        check("blk0_data", obs_block(), blk_a0);

        repeat (3) tick();
        check("done_hold_r_o", r_o, 1'b1);
        check("done_hold_busy", busy_o, 1'b0);
        check("done_hold_data", obs_block(), blk_a0);

        // One idle cycle between back-to-back blocks.
        @(negedge clk);
        u_i = 1'b0;
        tick();
        check("gap_r_o", r_o, 1'b0);
        check("gap_busy", busy_o, 1'b0);
        check("gap_data_hold", obs_block(), blk_a0);
        model_bytes(NB, '0, exp);
        request_block(-1, 32'h0, nb, nc);
        check("b2b_busy_cycles", nb, 64);
        check("b2b_ready_cycle", nc, 65);
        check("b2b_data", obs_block(), exp);
        release_req();
        check("b2b_release_r_o", r_o, 1'b0);

        // Seed 1 loaded while idle.
        @(negedge clk);
        seed_v_i = 1'b1;
        seed_i   = 32'h0000_0001;
        tick();
        seed_v_i = 1'b0;
        m_lfsr = 32'h0000_0001;
        model_bytes(NB, '0, exp);
        request_block(-1, 32'h0, nb, nc);
        check("seed1_data", obs_block(), exp);
        release_req();

        // Zero seed in the same cycle as the request falls back to SEED.
        m_lfsr = SEED;
        model_bytes(NB, '0, exp);
        request_block(0, 32'h0, nb, nc);
        check("seed0_ready_cycle", nc, 65);
        check("seed0_data", obs_block(), exp);
        prev = exp;
        release_req();

        // Abort after 10 fill cycles.
        model_bytes(10, prev, exp);
        saw_ready = 1'b0;
        @(negedge clk);
        u_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            saw_ready |= r_o;
        end
        check("abort_busy_in_fill", busy_o, 1'b1);
        @(negedge clk);
        u_i = 1'b0;
        tick();
        saw_ready |= r_o;
        check("abort_busy", busy_o, 1'b0);
        check("abort_no_ready", saw_ready, 1'b0);
        check("abort_data", obs_block(), exp);
        repeat (3) tick();
        check("abort_idle_hold", obs_block(), exp);
        model_bytes(NB, '0, exp);
        request_block(-1, 32'h0, nb, nc);
        check("resume_ready_cycle", nc, 65);
        check("resume_data", obs_block(), exp);
        release_req();

        // Seed strobe during FILL is ignored.
        model_bytes(NB, '0, exp);
        request_block(20, 32'h1234_5678, nb, nc);
        check("fill_seed_ready_cycle", nc, 65);
        check("fill_seed_data", obs_block(), exp);

        // Seed strobe during DONE is ignored.
        @(negedge clk);
        seed_v_i = 1'b1;
        seed_i   = 32'h0000_0042;
        tick();
        seed_v_i = 1'b0;
        check("done_seed_r_o", r_o, 1'b1);
        release_req();
        model_bytes(NB, '0, exp);
        request_block(-1, 32'h0, nb, nc);
        check("done_seed_data", obs_block(), exp);
        release_req();

        // Reset at fill cycle 30, with request and seed strobe also high.
        @(negedge clk);
        u_i = 1'b1;
        tick();
        repeat (30) tick();
        check("fill30_busy", busy_o, 1'b1);
        @(negedge clk);
        areset   = 1'b1;
        seed_v_i = 1'b1;
        seed_i   = 32'hDEAD_BEEF;
        tick();
        check("rst_fill_r_o", r_o, 1'b0);
        check("rst_fill_busy", busy_o, 1'b0);
        check("rst_fill_data", obs_block(), '0);
        @(negedge clk);
        areset   = 1'b0;
        seed_v_i = 1'b0;
        u_i      = 1'b0;
        tick();
        request_block(-1, 32'h0, nb, nc);
        check("post_rst1_ready_cycle", nc, 65);
        check("post_rst1_data", obs_block(), blk_a0);

        // Reset while in DONE with the request still held.
        @(negedge clk);
        areset = 1'b1;
        tick();
        check("rst_done_r_o", r_o, 1'b0);
        check("rst_done_busy", busy_o, 1'b0);
        check("rst_done_data", obs_block(), '0);
        @(negedge clk);
        areset = 1'b0;
        u_i    = 1'b0;
        tick();
        request_block(-1, 32'h0, nb, nc);
        check("post_rst2_data", obs_block(), blk_a0);
        release_req();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
